nn_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the SoC's single-port synchronous RAM between the core's instruction-fetch port and its load/store port. It sits between the nnRv core and the RAM array inside the SoC top. It multiplexes address, write data and byte enables onto the RAM and routes read data back to the requester that issued the read. Load/store has priority, and a bounded-run counter guarantees that instruction fetch cannot starve.

---
 rtl/nn_mem_arbiter_if.sv | 37 +++
 rtl/nn_mem_arbiter.sv | 78 +++++++
 tb/tb_nn_mem_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/nn_mem_arbiter_if.sv
// Core-side request/response and RAM-side buses of the fetch/load-store RAM arbiter.
// Modport 'arb' is the arbiter view; 'env' is the view of the core and the RAM array.
interface nn_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic            IF_REQ;
  logic [AW-1:0]   IF_ADDR;
  logic            IF_GNT;
  logic            IF_RVALID;
  logic [DW-1:0]   IF_RDATA;
  logic            LS_REQ;
  logic            LS_WE;
  logic [AW-1:0]   LS_ADDR;
  logic [DW-1:0]   LS_WDATA;
  logic [DW/8-1:0] LS_BE;
  logic            LS_GNT;
  logic            LS_RVALID;
  logic [DW-1:0]   LS_RDATA;
  logic            RAM_EN;
  logic [DW/8-1:0] RAM_WE;
  logic [AW-1:0]   RAM_ADDR;
  logic [DW-1:0]   RAM_WDATA;
  logic [DW-1:0]   RAM_RDATA;

  modport arb (
    input  IF_REQ, IF_ADDR, LS_REQ, LS_WE, LS_ADDR, LS_WDATA, LS_BE, RAM_RDATA,
    output IF_GNT, IF_RVALID, IF_RDATA, LS_GNT, LS_RVALID, LS_RDATA,
           RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA
  );

  modport env (
    output IF_REQ, IF_ADDR, LS_REQ, LS_WE, LS_ADDR, LS_WDATA, LS_BE, RAM_RDATA,
    input  IF_GNT, IF_RVALID, IF_RDATA, LS_GNT, LS_RVALID, LS_RDATA,
           RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA
  );
endinterface

// File: rtl/nn_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// Load/store wins contention until it has taken MAX_LS_RUN grants in a row over a waiting fetch.
module nn_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MAX_LS_RUN = 4
) (
  input  logic CLK,
  input  logic RST,
  nn_mem_arbiter_if.arb bus
);
  localparam int BW = DW / 8;
  localparam logic [3:0] MAX_RUN = 4'(MAX_LS_RUN);

  logic [3:0] run_cnt_q, run_cnt_d;
  logic       rd_if_q, rd_if_d;
  logic       rd_ls_q, rd_ls_d;
  logic       ls_win, if_win;

  always_comb begin
    ls_win = 1'b0;
    if_win = 1'b0;
    if (!RST) begin
      if (bus.LS_REQ && (!bus.IF_REQ || run_cnt_q != MAX_RUN)) ls_win = 1'b1;
      else if (bus.IF_REQ)                                     if_win = 1'b1;
    end
  end

  always_comb begin
    bus.IF_GNT    = if_win;
    bus.LS_GNT    = ls_win;
    bus.RAM_EN    = if_win | ls_win;
    bus.RAM_WE    = '0;
    bus.RAM_ADDR  = '0;
    bus.RAM_WDATA = '0;
    if (ls_win) begin
      bus.RAM_ADDR = bus.LS_ADDR;
      if (bus.LS_WE) begin
        bus.RAM_WE    = bus.LS_BE;
        bus.RAM_WDATA = bus.LS_WDATA;
      end
    end else if (if_win) begin
      bus.RAM_ADDR = bus.IF_ADDR;
    end
  end

  // The run only counts grants taken while fetch is actually waiting.
  always_comb begin
    run_cnt_d = 4'd0;
    if (ls_win && bus.IF_REQ)
      run_cnt_d = (run_cnt_q == MAX_RUN) ? MAX_RUN : run_cnt_q + 4'd1;
    rd_if_d = if_win;
    rd_ls_d = ls_win && !bus.LS_WE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      run_cnt_q <= 4'd0;
      rd_if_q   <= 1'b0;
      rd_ls_q   <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      rd_if_q   <= rd_if_d;
      rd_ls_q   <= rd_ls_d;
    end
  end

  // Gate with RST so a read granted just before reset never returns.
  always_comb begin
    bus.IF_RVALID = rd_if_q && !RST;
    bus.LS_RVALID = rd_ls_q && !RST;
    bus.IF_RDATA  = bus.IF_RVALID ? bus.RAM_RDATA : '0;
    bus.LS_RDATA  = bus.LS_RVALID ? bus.RAM_RDATA : '0;
  end

  logic [BW-1:0] unused_be;
  assign unused_be = '0;
endmodule

// File: tb/tb_nn_mem_arbiter.sv
// Directed plus random bench for nn_mem_arbiter with a RAM array and an abstract arbiter model.
module tb_nn_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MAX_LS_RUN = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  nn_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  nn_mem_arbiter #(.AW(AW), .DW(DW), .MAX_LS_RUN(MAX_LS_RUN)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  // RAM array environment
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'(i) * 32'h9E3779B1;
    ram[3] = 32'h0;
    ram[5] = 32'h00000013;
  end
  always @(posedge CLK) begin
    if (bus.RAM_EN) begin
      bus.RAM_RDATA <= ram[bus.RAM_ADDR];
      for (int b = 0; b < BW; b++)
        if (bus.RAM_WE[b]) ram[bus.RAM_ADDR][8*b +: 8] <= bus.RAM_WDATA[8*b +: 8];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            streak;
  logic          exp_if_rv, exp_ls_rv;
  logic [DW-1:0] exp_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic          obs_if_gnt, obs_ls_gnt, obs_if_rv, obs_ls_rv;
  logic [DW-1:0] obs_if_rdata, obs_ls_rdata;
  logic          g_if, g_ls;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic ifr, input logic [AW-1:0] ifa,
                      input logic lsr, input logic lswe, input logic [AW-1:0] lsa,
                      input logic [DW-1:0] wd, input logic [BW-1:0] be);
    logic [AW-1:0] e_addr;
    logic          wr;
    RST = rst;
    bus.IF_REQ = ifr; bus.IF_ADDR = ifa;
    bus.LS_REQ = lsr; bus.LS_WE = lswe; bus.LS_ADDR = lsa; bus.LS_WDATA = wd; bus.LS_BE = be;
    #1;
    g_ls = !rst && lsr && (!ifr || streak < MAX_LS_RUN);
    g_if = !rst && ifr && !g_ls;
    wr   = g_ls && lswe;
    e_addr = g_ls ? lsa : (g_if ? ifa : '0);
    obs_if_gnt = bus.IF_GNT;    obs_ls_gnt = bus.LS_GNT;
    obs_if_rv  = bus.IF_RVALID; obs_ls_rv  = bus.LS_RVALID;
    obs_if_rdata = bus.IF_RDATA; obs_ls_rdata = bus.LS_RDATA;
    chk("if_gnt",    DW'(bus.IF_GNT), DW'(g_if));
    chk("ls_gnt",    DW'(bus.LS_GNT), DW'(g_ls));
    chk("ram_en",    DW'(bus.RAM_EN), DW'(g_if | g_ls));
    chk("ram_addr",  DW'(bus.RAM_ADDR), DW'(e_addr));
    chk("ram_we",    DW'(bus.RAM_WE), wr ? DW'(be) : '0);
    chk("ram_wdata", bus.RAM_WDATA, wr ? wd : '0);
    chk("if_rvalid", DW'(bus.IF_RVALID), DW'(!rst && exp_if_rv));
    chk("ls_rvalid", DW'(bus.LS_RVALID), DW'(!rst && exp_ls_rv));
    chk("if_rdata",  bus.IF_RDATA, (!rst && exp_if_rv) ? exp_rdata : '0);
    chk("ls_rdata",  bus.LS_RDATA, (!rst && exp_ls_rv) ? exp_rdata : '0);
    @(posedge CLK);
    if (rst) begin
      streak = 0; exp_if_rv = 1'b0; exp_ls_rv = 1'b0;
    end else begin
      exp_if_rv = g_if;
      exp_ls_rv = g_ls && !lswe;
      if (g_if) exp_rdata = ref_mem[ifa];
      else if (g_ls && !lswe) exp_rdata = ref_mem[lsa];
      if (wr)
        for (int b = 0; b < BW; b++)
          if (be[b]) ref_mem[lsa][8*b +: 8] = wd[8*b +: 8];
      streak = (g_ls && ifr) ? streak + 1 : 0;
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic          if_p, ls_p, ls_we_p;
    logic [AW-1:0] if_a, ls_a;
    logic [DW-1:0] ls_wd;
    logic [BW-1:0] ls_be;
    logic          r;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'(i) * 32'h9E3779B1;
    ref_mem[3] = 32'h0;
    ref_mem[5] = 32'h00000013;
    streak = 0; exp_if_rv = 1'b0; exp_ls_rv = 1'b0; exp_rdata = '0;
    RST = 1'b1;
    bus.IF_REQ = 1'b0; bus.IF_ADDR = '0; bus.LS_REQ = 1'b0; bus.LS_WE = 1'b0;
    bus.LS_ADDR = '0; bus.LS_WDATA = '0; bus.LS_BE = '0;
    @(negedge CLK);

    // reset with both requesting, then release: LS must win first
    repeat (3) step(1'b1, 1'b1, 10'd5, 1'b1, 1'b0, 10'd1, '0, '0);
    step(1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 10'd1, '0, '0);
    chk("rel_ls_first", DW'(obs_ls_gnt), DW'(1));
    step(1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, '0, '0);
    idle();

    // fetch read
    step(1'b0, 1'b1, 10'd5, 1'b0, 1'b0, '0, '0, '0);
    chk("fetch_gnt", DW'(obs_if_gnt), DW'(1));
    idle();
    chk("fetch_rv", DW'(obs_if_rv), DW'(1));
    chk("fetch_data", obs_if_rdata, 32'h00000013);
    chk("fetch_no_lsrv", DW'(obs_ls_rv), DW'(0));

    // byte write then read back
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 10'd3, 32'hAABBCCDD, 4'b0010);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 10'd3, '0, '0);
    chk("wr_no_rv", DW'(obs_ls_rv), DW'(0));
    idle();
    chk("be_rv", DW'(obs_ls_rv), DW'(1));
    chk("be_data", obs_ls_rdata, 32'h0000CC00);

    // contention: LS,LS,LS,LS,IF repeating
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 10'd7, 1'b1, 1'b0, 10'(k + 8), '0, '0);
      chk("cont_if", DW'(obs_if_gnt), DW'(k == 4 || k == 9));
    end
    idle();

    // back-to-back reads
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 10'd1, '0, '0);
    step(1'b0, 1'b1, 10'd2, 1'b0, 1'b0, '0, '0, '0);
    chk("b2b_ls_rv", DW'(obs_ls_rv), DW'(1));
    chk("b2b_ls_data", obs_ls_rdata, 32'(1) * 32'h9E3779B1);
    idle();
    chk("b2b_if_rv", DW'(obs_if_rv), DW'(1));
    chk("b2b_if_data", obs_if_rdata, 32'(2) * 32'h9E3779B1);

    // reset right after a granted read
    step(1'b0, 1'b1, 10'd9, 1'b1, 1'b0, 10'd4, '0, '0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    chk("rst_no_rv", DW'(obs_ls_rv), DW'(0));
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 10'd7, 1'b1, 1'b0, 10'd6, '0, '0);
      chk("post_rst_run", DW'(obs_if_gnt), DW'(k == 4));
    end
    idle();

    // random traffic with held requests
    if_p = 1'b0; ls_p = 1'b0; if_a = '0; ls_a = '0; ls_we_p = 1'b0; ls_wd = '0; ls_be = '0;
    for (int n = 0; n < 400; n++) begin
      if (!if_p && $urandom_range(0, 3) != 0) begin
        if_p = 1'b1; if_a = 10'($urandom_range(0, 15));
      end
      if (!ls_p && $urandom_range(0, 3) != 0) begin
        ls_p = 1'b1; ls_a = 10'($urandom_range(0, 15)); ls_we_p = 1'($urandom);
        ls_wd = $urandom; ls_be = 4'($urandom);
      end
      r = ($urandom_range(0, 49) == 0);
      step(r, if_p, if_a, ls_p, ls_we_p, ls_a, ls_wd, ls_be);
      if (g_if) if_p = 1'b0;
      if (g_ls) ls_p = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
